// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer
//
// Iterative shift-and-add multiplier controller. It computes the low LENGTH
// bits of op_a * op_b by reusing one external LENGTH-bit adder, one multiplier
// bit per cycle. It stops early once no set multiplier bits remain, so a
// multiply takes (index of highest set bit of op_b) + 1 cycles. That is at
// least 1 and at most LENGTH.
//
// Parameters
//   LENGTH      operand / result / adder width
//   CNT_W       iteration counter width; 2**CNT_W must exceed LENGTH
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset, clears all state
//   start       request pulse, only looked at while idle
//   op_a        multiplicand, captured with start
//   op_b        multiplier, captured with start
//   add_a       operand A driven to the shared adder (0 when idle)
//   add_b       operand B driven to the shared adder (0 when idle)
//   add_result  combinational sum returned by the shared adder
//   busy        high while a multiply is in progress
//   done        single-cycle pulse when result is updated
//   result      registered product, held until the next completion
// ---------------------------------------------------------------------------
module mult_sequencer #(
    parameter int LENGTH = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LENGTH-1:0] op_a,
    input  logic [LENGTH-1:0] op_b,
    output logic [LENGTH-1:0] add_a,
    output logic [LENGTH-1:0] add_b,
    input  logic [LENGTH-1:0] add_result,
    output logic              busy,
    output logic              done,
    output logic [LENGTH-1:0] result
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);

    state_t            r_state;
    logic [LENGTH-1:0] r_acc;
    logic [LENGTH-1:0] r_mcand;
    logic [LENGTH-1:0] r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic [LENGTH-1:0] r_result;
    logic              r_done;

    logic              w_run;
    logic              w_last;

    assign w_run = (r_state == RUN);

    // Early exit: once the bits above the one being consumed this cycle are
    // all clear, later iterations would only add zero. The counter bound
    // covers the case where the top multiplier bit is set.
    assign w_last = (r_cnt == LAST_CNT) || (r_mplier[LENGTH-1:1] == '0);

    // The adder is held at 0 + 0 while idle so it does not toggle.
    assign add_a = w_run ? r_acc : '0;
    assign add_b = (w_run && r_mplier[0]) ? r_mcand : '0;

    assign busy   = w_run;
    assign done   = r_done;
    assign result = r_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            // done is a pulse; it only survives the edge that sets it.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Also taken in the done cycle, which gives back-to-back
                    // multiplies with no idle bubble.
                    if (start) begin
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    // Partial product for the current multiplier bit is
                    // folded in by the external adder this cycle.
                    r_acc    <= add_result;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= add_result;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

    localparam int LENGTH = 32;
    localparam int CNT_W  = 6;

    logic              clk;
    logic              reset;
    logic              start;
    logic [LENGTH-1:0] op_a;
    logic [LENGTH-1:0] op_b;
    logic [LENGTH-1:0] add_a;
    logic [LENGTH-1:0] add_b;
    logic [LENGTH-1:0] add_result;
    logic              busy;
    logic              done;
    logic [LENGTH-1:0] result;

    mult_sequencer #(.LENGTH(LENGTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    // The shared adder lives outside the sequencer.
    assign add_result = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LENGTH-1:0] res;
        int                runs;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [LENGTH-1:0] act,
                         input logic [LENGTH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: consumes expected completions whenever done is presented.
    int                run_cnt   = 0;
    logic              prev_done = 1'b0;
    logic [LENGTH-1:0] last_res  = '0;

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            run_cnt   = 0;
            prev_done = 1'b0;
            last_res  = '0;
        end else begin
            if (busy) run_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with result 0x%08h, required no done", result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("run_cycles", LENGTH'(run_cnt), LENGTH'(e.runs));
                    check("busy_at_done", LENGTH'(busy), '0);
                end
                if (prev_done) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL done_width: got done high two cycles, required one");
                end
                run_cnt  = 0;
                last_res = result;
            end else begin
                check("result_hold", result, last_res);
            end
            prev_done = done;
        end
    end

    // Drive a start pulse at a falling edge; returns one cycle later.
    task automatic issue(input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b,
                         input logic push, input logic [LENGTH-1:0] res,
                         input int runs);
        exp_t e;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        if (push) begin
            e.res  = res;
            e.runs = runs;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no done in 60 cycles, required done", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", LENGTH'(busy), '0);
        check("rst_done", LENGTH'(done), '0);
        check("rst_result", result, '0);
        check("rst_add_a", add_a, '0);
        check("rst_add_b", add_b, '0);
        reset = 1'b1;
        @(negedge clk);

        // 7 * 6 = 42, three RUN cycles
        issue(32'd7, 32'd6, 1'b1, 32'd42, 3);
        wait_done("basic");
        @(negedge clk);

        // -3 * 5 = -15
        issue(32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFF1, 3);
        wait_done("signed");
        @(negedge clk);

        // op_b = 0: one RUN cycle, adder B operand stays zero
        issue(32'h1234_5678, 32'd0, 1'b1, 32'd0, 1);
        check("min_add_b", add_b, '0);
        check("min_add_a", add_a, '0);
        wait_done("min");
        @(negedge clk);

        // All ones squared, full LENGTH iterations
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd1, 32);
        wait_done("max");
        @(negedge clk);

        // 9 * 3 with an ignored start while busy, then 2 * 2 back-to-back
        issue(32'd9, 32'd3, 1'b1, 32'd27, 2);
        issue(32'd100, 32'd100, 1'b0, '0, 0);
        wait_done("busy_start");
        issue(32'd2, 32'd2, 1'b1, 32'd4, 2);
        check("b2b_busy", LENGTH'(busy), LENGTH'(1));
        wait_done("b2b");
        @(negedge clk);

        // Reset in the middle of 0xFFFF * 0xFFFF
        issue(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, '0, 0);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", LENGTH'(busy), '0);
        check("midrst_done", LENGTH'(done), '0);
        check("midrst_result", result, '0);
        check("midrst_add_a", add_a, '0);
        check("midrst_add_b", add_b, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 4 * 5 = 20 after the aborted multiply
        issue(32'd4, 32'd5, 1'b1, 32'd20, 3);
        wait_done("post_reset");
        repeat (3) @(negedge clk);

        check("pending_expected", LENGTH'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Iterative shift-and-add multiplier controller for the ALU.
- It sequences one shared LENGTH-bit adder over several cycles to produce the low LENGTH bits of A*B.
- It drives the adder's operand inputs and consumes its combinational sum. The adder itself stays a separate instance outside this block.
- It has a start/busy/done handshake toward the control unit. The datapath stalls on busy.

Parameters:
- LENGTH, 32, operand/result width; also the adder width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > LENGTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  LENGTH  multiplicand; sampled with start.
- op_b  input  LENGTH  multiplier; sampled with start.
- add_a  output  LENGTH  operand A to the shared adder.
- add_b  output  LENGTH  operand B to the shared adder.
- add_result  input  LENGTH  adder sum; combinational, same cycle.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  LENGTH  registered product, low LENGTH bits; held until the next completion.

Behaviour:
- States: IDLE, RUN. Registers: state, acc, mcand, mplier, cnt, result, done.
- Reset (reset=0, asynchronous): state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, result=0, done=0, busy=0. This applies mid-operation too; the in-flight multiply is discarded.
- IDLE, start=1 at an edge:
  - mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0, state<=RUN.
  - start=0: remain in IDLE.
- RUN, each cycle (combinational):
  - add_a=acc.
  - add_b = mplier[0] ? mcand : 0.
- RUN, at each edge:
  - acc<=add_result.
  - mcand<=mcand<<1 (zero fill, bits shifted out dropped).
  - mplier<=mplier>>1 (logical).
  - cnt<=cnt+1.
- Termination, evaluated in RUN: last = (cnt==LENGTH-1) OR (mplier[LENGTH-1:1]==0). This is early exit once no set multiplier bits remain.
- On the edge where last=1: result<=add_result, done<=1, state<=IDLE.
- done is high exactly one cycle, and is cleared at the next edge.
- busy = (state==RUN), decoded from state.
- IDLE outputs: add_a=0, add_b=0.
- RUN cycles = index of highest set bit of op_b, plus 1. Minimum is 1 (op_b=0 or 1); maximum is LENGTH.
- Latency: start sampled at edge E0; done high in the cycle after edge E_N, where N = RUN cycles.
- Arithmetic:
  - All adds are modulo 2^LENGTH; overflow is ignored.
  - The low LENGTH bits are identical for signed and unsigned operands, so no sign handling is needed.
- start while busy=1: ignored; operands are not re-sampled.
- start in the same cycle done=1: accepted (state is already IDLE), giving back-to-back operation with no bubble.
- op_a/op_b changes after sampling have no effect.
- result is stable between done pulses.

Test Plan:
- Basic timing: reset, then start with op_a=7, op_b=6.
  - Required: busy high for exactly 3 cycles.
  - done pulses once in the cycle after the 3rd RUN edge.
  - result=42.
- Signed operands: op_a=0xFFFFFFFD (-3), op_b=5.
  - Required: 3 RUN cycles, result=0xFFFFFFF1 (-15).
- Minimum length: op_b=0, op_a=0x12345678.
  - Required: 1 RUN cycle, result=0.
  - add_b=0 throughout.
- Maximum length: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF.
  - Required: 32 RUN cycles, result=0x00000001.
- Handshake robustness:
  - Start 9*3. Pulse start with op_a=100, op_b=100 while busy.
    - Required: result=27; no second done.
  - Then start 2*2 in the done cycle.
    - Required: next done yields result=4, with RUN entered on that edge.
- Reset mid-operation: start 0xFFFF*0xFFFF, assert reset after 5 RUN cycles.
  - Required: immediately busy=0, done=0, result=0, add_a=add_b=0.
  - A subsequent 4*5 yields 20.
